// File: rtl/bit_stream_serializer_if.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer_if
//  Description : Word handshake and serial output bundle for
//                bit_stream_serializer.
//                master = upstream word source / downstream observer side
//                slave  = serializer side
//  Signals     : din        [WIDTH] parallel word (master -> slave)
//                din_valid  [1]     din holds a word (master -> slave)
//                din_ready  [1]     serializer accepts a word (slave -> master)
//                en         [1]     shift enable, 0 freezes (master -> slave)
//                x          [1]     serial bit, MSB first (slave -> master)
//                x_valid    [1]     x carries a data bit (slave -> master)
//                frame_done [1]     pulse with last bit of frame (slave -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface bit_stream_serializer_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             en;
   logic             x;
   logic             x_valid;
   logic             frame_done;

   modport master (
      output din, din_valid, en,
      input  din_ready, x, x_valid, frame_done
   );

   modport slave (
      input  din, din_valid, en,
      output din_ready, x, x_valid, frame_done
   );
endinterface
`default_nettype wire

// File: rtl/bit_stream_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bit_stream_serializer
//  Description : Parallel-to-serial front end for the 1101 sequence detector.
//                Loads WIDTH-bit words over valid/ready and emits them
//                MSB-first, one bit per enabled clock, with gap-free
//                back-to-back frames and a freeze enable.
//  Ports       : clk  - system clock, rising edge
//                clr  - synchronous reset, active-high
//                bus  - bit_stream_serializer_if.slave
//                       (din, din_valid, din_ready, en, x, x_valid, frame_done)
//  Parameters  : WIDTH    - word length, 2..32
//                IDLE_BIT - value on x while no word is being shifted
//  Options     : SERIALIZER_PARITY_EN - when defined, appends an even parity
//                bit after the data bits (frame = WIDTH+1 bits)
//  Revision    : 1.0 - initial release
// ============================================================================
module bit_stream_serializer #(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_BIT = 1'b0
) (
   input  wire logic              clk,
   input  wire logic              clr,
   bit_stream_serializer_if.slave bus
);

   localparam int               CNT_W  = ($clog2(WIDTH) > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

`ifdef SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_PARITY = 2'd2
   } state_t;
`else
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1
   } state_t;
`endif

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [WIDTH-1:0] shift_q;
   logic             x_q;
   logic             x_valid_q;
   logic             frame_done_q;
   logic             ready_state;
   logic             load;
`ifdef SERIALIZER_PARITY_EN
   logic             parity_q;
`endif

   assign cnt_d = cnt_q + 1'b1;

   // States in which a new word may be taken. The final bit of a frame
   // accepts the next word so consecutive frames run without a bubble.
   always_comb begin
      ready_state = 1'b0;
      case (state_q)
         ST_IDLE:   ready_state = 1'b1;
`ifdef SERIALIZER_PARITY_EN
         ST_SHIFT:  ready_state = 1'b0;
         ST_PARITY: ready_state = 1'b1;
`else
         ST_SHIFT:  ready_state = (cnt_q == C_LAST);
`endif
         default:   ready_state = 1'b0;
      endcase
   end

   assign bus.din_ready = ~clr & bus.en & ready_state;
   assign load          = bus.din_valid & bus.din_ready;

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         shift_q      <= '0;
         x_q          <= IDLE_BIT;
         x_valid_q    <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef SERIALIZER_PARITY_EN
         parity_q     <= 1'b0;
`endif
      end else if (bus.en) begin
         // frame_done is a single pulse; only entering the final bit sets it
         frame_done_q <= 1'b0;
         if (load) begin
            state_q   <= ST_SHIFT;
            cnt_q     <= '0;
            shift_q   <= bus.din;
            x_q       <= bus.din[WIDTH-1];
            x_valid_q <= 1'b1;
`ifdef SERIALIZER_PARITY_EN
            parity_q  <= ^bus.din;
`endif
         end else begin
            case (state_q)
               ST_SHIFT: begin
                  if (cnt_q == C_LAST) begin
`ifdef SERIALIZER_PARITY_EN
                     state_q      <= ST_PARITY;
                     x_q          <= parity_q;
                     x_valid_q    <= 1'b1;
                     frame_done_q <= 1'b1;
`else
                     // Counter is left at its last value; it only
                     // restarts on the next load.
                     state_q      <= ST_IDLE;
                     x_q          <= IDLE_BIT;
                     x_valid_q    <= 1'b0;
`endif
                  end else begin
                     shift_q      <= {shift_q[WIDTH-2:0], 1'b0};
                     x_q          <= shift_q[WIDTH-2];
                     x_valid_q    <= 1'b1;
                     cnt_q        <= cnt_d;
`ifdef SERIALIZER_PARITY_EN
                     frame_done_q <= 1'b0;
`else
                     frame_done_q <= (cnt_d == C_LAST);
`endif
                  end
               end
`ifdef SERIALIZER_PARITY_EN
               ST_PARITY: begin
                  state_q   <= ST_IDLE;
                  x_q       <= IDLE_BIT;
                  x_valid_q <= 1'b0;
               end
`endif
               default: begin
                  state_q   <= ST_IDLE;
                  x_q       <= IDLE_BIT;
                  x_valid_q <= 1'b0;
               end
            endcase
         end
      end else begin
         // Frozen: everything holds except the done pulse, which must not
         // repeat while the last bit is held on x.
         frame_done_q <= 1'b0;
      end
   end

   assign bus.x          = x_q;
   assign bus.x_valid    = x_valid_q;
   assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
